// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the boot byte stream, the instruction-memory write
// port and the core-release status of imem_loader.
//   rx_valid/rx_data/rx_ready    byte stream, transfer when valid && ready
//   imem_we/imem_addr/imem_wdata instruction-memory write port
//   core_hold/load_done/load_err core release and load status
//   word_count                   header word count N as received
// modport slave  : the loader side (consumes bytes, drives memory/status)
// modport master : the environment side (supplies bytes, observes the rest)
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_hold;
  logic                  load_done;
  logic                  load_err;
  logic [15:0]           word_count;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata,
           core_hold, load_done, load_err, word_count
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
           core_hold, load_done, load_err, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader. Receives a 16-bit
// little-endian word count N followed by 4N payload bytes, assembles
// little-endian 32-bit words and writes them to consecutive word addresses
// starting at BASE_ADDR. The pipeline core is held in reset until the last
// write has completed.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - imem_loader_if.slave (byte stream, imem write port, status)
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing byte
// equal to the XOR of all payload bytes before the core is released.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam logic [2:0] S_HDR_LO = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd6;
  localparam logic [2:0] S_AFTER  = S_CSUM;
`else
  localparam logic [2:0] S_AFTER  = S_DONE;
`endif

  // Words that fit between BASE_ADDR and the top of memory.
  localparam logic [31:0] CAPACITY = 32'((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR));

  logic [2:0]  state;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;     // bytes 0..2 of the word being assembled
  logic [15:0] word_idx;
  logic [15:0] n_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        ready_state;
  logic        accept;
  logic [15:0] n_next;
  logic        last_word;

`ifdef LOADER_CHECKSUM_EN
  assign ready_state = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                       (state == S_LOAD)   || (state == S_CSUM);
`else
  assign ready_state = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                       (state == S_LOAD);
`endif

  // Ready depends on state only; it is forced low while reset is applied.
  assign bus.rx_ready   = ready_state && !rst;
  assign accept         = bus.rx_valid && bus.rx_ready;
  assign n_next         = {bus.rx_data, n_q[7:0]};
  assign last_word      = (word_idx == n_q - 16'd1);

  assign bus.core_hold  = (state != S_DONE);
  assign bus.load_done  = (state == S_DONE);
  assign bus.load_err   = (state == S_ERROR);
  assign bus.word_count = n_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_HDR_LO;
      byte_idx       <= 2'd0;
      asm_q          <= 24'd0;
      word_idx       <= 16'd0;
      n_q            <= 16'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= 8'd0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      bus.imem_we <= 1'b0;
      case (state)
        S_HDR_LO: begin
          if (accept) begin
            n_q[7:0] <= bus.rx_data;
            state    <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            n_q[15:8] <= bus.rx_data;
            if (n_next == 16'd0)
              state <= S_AFTER;
            else if ({16'd0, n_next} > CAPACITY)
              state <= S_ERROR;
            else
              state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;  // wraps to 0 after the 4th byte
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= {bus.rx_data, asm_q};
              bus.imem_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
              word_idx       <= word_idx + 16'd1;
              if (last_word)
                state <= S_FLUSH;
            end else begin
              asm_q[8*byte_idx +: 8] <= bus.rx_data;
            end
          end
        end
        // The final write strobe is high during this cycle; release waits.
        S_FLUSH: state <= S_AFTER;
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept)
            state <= (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
        end
`endif
        S_DONE:  state <= S_DONE;
        S_ERROR: state <= S_ERROR;
        // Unreachable encodings keep the core held.
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (ADDR_WIDTH=10, BASE_ADDR=0).
// Expected writes are queued as words are sent and popped by a monitor when
// the loader strobes imem_we. Builds with or without LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk;
  logic rst;
  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  wr_t  exp_q[$];
  logic [7:0] tb_xor;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_q_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", bus.imem_wdata, e.data);
      end
    end
  end

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rx_ready", bus.rx_ready, 0);
    rst = 1'b0;
    #1;
  endtask

  // Presents one byte after up to 'gap' bubble cycles; returns #1 after the
  // accepting edge with rx_valid still high (full rate when gap is 0).
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    if (gap > 0)
      repeat ($urandom_range(0, gap)) begin
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    waited = 0;
    while (bus.rx_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited == 20) check("rx_ready_timeout", bus.rx_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap);
    tb_xor = 8'h00;
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] addr, input int gap);
    exp_q.push_back('{addr: addr, data: w});
    for (int i = 0; i < 4; i++) begin
      tb_xor = tb_xor ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], gap);
    end
  endtask

  // Called right after the last header/payload byte has been accepted.
  task automatic end_load(input bit has_payload, input bit bad_csum);
    bit exp_ok;
    exp_ok = !bad_csum;
    if (has_payload) begin
      check("flush_we", bus.imem_we, 1);
      check("flush_hold", bus.core_hold, 1);
      check("flush_done", bus.load_done, 0);
`ifndef LOADER_CHECKSUM_EN
      @(posedge clk); #1;
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(tb_xor ^ {7'd0, bad_csum}, 0);
`endif
    bus.rx_valid = 1'b0;
    check("end_load_done", bus.load_done, 32'(exp_ok));
    check("end_load_err", bus.load_err, 32'(!exp_ok));
    check("end_core_hold", bus.core_hold, 32'(!exp_ok));
    check("end_rx_ready", bus.rx_ready, 0);
    check("end_we", bus.imem_we, 0);
    check("end_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    clk = 1'b0;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", 32'(bus.imem_addr), 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_core_hold", bus.core_hold, 1);
    check("rst_load_done", bus.load_done, 0);
    check("rst_load_err", bus.load_err, 0);
    check("rst_word_count", 32'(bus.word_count), 0);
    check("rst_ready_after", bus.rx_ready, 1);

    // N=2 at full rate
    w0 = wr_cnt;
    send_hdr(16'd2, 0);
    send_word(32'h00500093, 0, 0);
    send_word(32'h00A00113, 1, 0);
    end_load(1, 0);
    check("full_word_count", 32'(bus.word_count), 2);
    check("full_wr_cnt", wr_cnt - w0, 2);

    // Same image with random bubbles
    do_reset();
    w0 = wr_cnt;
    send_hdr(16'd2, 3);
    send_word(32'h00500093, 0, 3);
    send_word(32'h00A00113, 1, 3);
    end_load(1, 0);
    check("gap_word_count", 32'(bus.word_count), 2);
    check("gap_wr_cnt", wr_cnt - w0, 2);

    // Oversize image: N = 1025 > 1024
    do_reset();
    w0 = wr_cnt;
    send_hdr(16'h0401, 0);
    check("big_err", bus.load_err, 1);
    check("big_hold", bus.core_hold, 1);
    check("big_ready", bus.rx_ready, 0);
    check("big_word_count", 32'(bus.word_count), 32'h0401);
    bus.rx_data = 8'hA5;
    repeat (4) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    check("big_no_write", wr_cnt - w0, 0);
    check("big_ready_hold", bus.rx_ready, 0);
    check("big_err_hold", bus.load_err, 1);

    // Exactly full memory: N = 1024 is accepted
    do_reset();
    send_hdr(16'h0400, 0);
    bus.rx_valid = 1'b0;
    check("fit_err", bus.load_err, 0);
    check("fit_ready", bus.rx_ready, 1);

    // Reset after 6 payload bytes of an N=3 load
    do_reset();
    w0 = wr_cnt;
    send_hdr(16'd3, 0);
    send_word(32'hDEADBEEF, 0, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset();
    @(negedge clk); #1;
    check("midrst_wr_cnt", wr_cnt - w0, 1);
    check("midrst_we", bus.imem_we, 0);
    check("midrst_queue", exp_q.size(), 0);
    send_hdr(16'd1, 0);
    send_word(32'hCAFEF00D, 0, 0);
    end_load(1, 0);
    check("midrst_total_wr", wr_cnt - w0, 2);

    // N=1, good checksum (plain completion without the checksum option)
    do_reset();
    w0 = wr_cnt;
    send_hdr(16'd1, 0);
    send_word(32'h11223344, 0, 0);
    end_load(1, 0);
    check("one_wr_cnt", wr_cnt - w0, 1);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: write still happens, core stays held
    do_reset();
    w0 = wr_cnt;
    send_hdr(16'd1, 0);
    send_word(32'h11223344, 0, 0);
    end_load(1, 1);
    check("badcs_wr_cnt", wr_cnt - w0, 1);
`endif

    // N=0: completes without writes
    do_reset();
    w0 = wr_cnt;
    send_hdr(16'd0, 0);
    end_load(0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("zero_wr_cnt", wr_cnt - w0, 0);
    check("zero_word_count", 32'(bus.word_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
